// File: rtl/i2c_register_bank.sv
// i2c_register_bank: register file between the I2C slave core and the OSD
// character RAM. It provides a banked direct RAM window, an auto-incrementing
// stream port, write-protect, sticky flags and a coherent status snapshot.
//
// Ports
//   clk            system clock
//   reset_n        async active-low reset
//   addr           register address from the i2c slave
//   data_in        write data
//   write_en       write level; each rising edge gives one write
//   data_out       registered read data (1-cycle latency)
//   status_bus     flat status bus, byte k = [8k+7:8k]
//   ram_data       OSD RAM write data (held between writes)
//   ram_wraddress  OSD RAM write address (held between writes)
//   ram_wren       OSD RAM write strobe, one cycle
//   enable_osd     OSD enable
module i2c_register_bank #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        RAM_AW      = 10,
    parameter int unsigned        WIN_BITS    = 7,
    parameter int unsigned        NUM_STATUS  = 32,
    parameter logic [ADDR_W-1:0]  STATUS_BASE = 8'h90
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [7:0]              data_in,
    input  logic                    write_en,
    output logic [7:0]              data_out,
    input  logic [NUM_STATUS*8-1:0] status_bus,
    output logic [7:0]              ram_data,
    output logic [RAM_AW-1:0]       ram_wraddress,
    output logic                    ram_wren,
    output logic                    enable_osd
);

    localparam int unsigned BANK_W = RAM_AW - WIN_BITS;
    localparam int unsigned STAT_W = NUM_STATUS * 8;

    localparam logic [ADDR_W-1:0] CTRL_BASE = ADDR_W'(1 << WIN_BITS);
    localparam logic [ADDR_W-1:0] A_BANK    = ADDR_W'((1 << WIN_BITS) + 0);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'((1 << WIN_BITS) + 1);
    localparam logic [ADDR_W-1:0] A_PTRL    = ADDR_W'((1 << WIN_BITS) + 2);
    localparam logic [ADDR_W-1:0] A_PTRH    = ADDR_W'((1 << WIN_BITS) + 3);
    localparam logic [ADDR_W-1:0] A_STREAM  = ADDR_W'((1 << WIN_BITS) + 4);
    localparam logic [ADDR_W-1:0] A_FLAGS   = ADDR_W'((1 << WIN_BITS) + 5);
    localparam logic [ADDR_W-1:0] A_SNAP    = ADDR_W'((1 << WIN_BITS) + 6);

    logic              we_q;
    logic [BANK_W-1:0] bank;
    logic              write_protect;
    logic [RAM_AW-1:0] ptr;
    logic              flag_wrap;
    logic              flag_blocked;
    logic [STAT_W-1:0] snapshot;

    logic              wr_pulse_c;
    logic              win_sel_c;
    logic              ram_sel_c;
    logic [ADDR_W-1:0] stat_idx_c;
    logic              stat_sel_c;
    logic [7:0]        rd_data_c;

    // Address decode and write edge detect
    always_comb begin
        wr_pulse_c = write_en & ~we_q;
        win_sel_c  = (addr < CTRL_BASE);
        ram_sel_c  = win_sel_c || (addr == A_STREAM);
        stat_idx_c = addr - STATUS_BASE;
        stat_sel_c = (addr >= STATUS_BASE) && (32'(stat_idx_c) < NUM_STATUS);
    end

    // Read mux; unmapped and write-only addresses read 0
    always_comb begin
        rd_data_c = 8'h00;
        if (stat_sel_c) begin
            rd_data_c = 8'(snapshot >> {stat_idx_c, 3'b000});
        end else begin
            case (addr)
                A_BANK:  rd_data_c = 8'(bank);
                A_CTRL:  rd_data_c = {6'b0, write_protect, enable_osd};
                A_PTRL:  rd_data_c = 8'(ptr);
                A_PTRH:  rd_data_c = 8'(ptr >> 8);
                A_FLAGS: rd_data_c = {6'b0, flag_blocked, flag_wrap};
                default: rd_data_c = 8'h00;
            endcase
        end
    end

    // Register updates, RAM write port and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q          <= 1'b0;
            data_out      <= 8'h00;
            bank          <= '0;
            enable_osd    <= 1'b0;
            write_protect <= 1'b0;
            ptr           <= '0;
            flag_wrap     <= 1'b0;
            flag_blocked  <= 1'b0;
            snapshot      <= '0;
            ram_wren      <= 1'b0;
            ram_data      <= 8'h00;
            ram_wraddress <= '0;
        end else begin
            we_q     <= write_en;
            data_out <= rd_data_c;
            ram_wren <= 1'b0;
            if (wr_pulse_c) begin
                if (ram_sel_c) begin
                    // Protected RAM writes are dropped and recorded as BLOCKED
                    if (write_protect) begin
                        flag_blocked <= 1'b1;
                    end else begin
                        ram_wren <= 1'b1;
                        ram_data <= data_in;
                        if (win_sel_c) begin
                            ram_wraddress <= {bank, addr[WIN_BITS-1:0]};
                        end else begin
                            ram_wraddress <= ptr;
                            ptr           <= ptr + RAM_AW'(1);
                            if (&ptr) begin
                                flag_wrap <= 1'b1;
                            end
                        end
                    end
                end else begin
                    case (addr)
                        A_BANK: bank <= BANK_W'(data_in);
                        A_CTRL: begin
                            enable_osd    <= data_in[0];
                            write_protect <= data_in[1];
                            if (data_in[2]) begin
                                flag_wrap    <= 1'b0;
                                flag_blocked <= 1'b0;
                            end
                        end
                        // Keep the other half of the pointer; excess PTR_H bits drop off
                        A_PTRL: ptr <= RAM_AW'({ptr >> 8, data_in});
                        A_PTRH: ptr <= RAM_AW'({data_in, ptr[7:0]});
                        A_SNAP: snapshot <= status_bus;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed testbench for i2c_register_bank.
module tb_i2c_register_bank;

    logic         clk;
    logic         reset_n;
    logic [7:0]   addr;
    logic [7:0]   data_in;
    logic         write_en;
    logic [7:0]   data_out;
    logic [255:0] status_bus;
    logic [7:0]   ram_data;
    logic [9:0]   ram_wraddress;
    logic         ram_wren;
    logic         enable_osd;

    int n_cmp;
    int n_bad;
    int wren_cnt;

    logic       cap_wren;
    logic [9:0] cap_addr;
    logic [7:0] cap_data;
    logic       cap_en;
    logic [7:0] rd;
    int         c0;

    i2c_register_bank dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr          (addr),
        .data_in       (data_in),
        .write_en      (write_en),
        .data_out      (data_out),
        .status_bus    (status_bus),
        .ram_data      (ram_data),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .enable_osd    (enable_osd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ram_wren === 1'b1) wren_cnt++;

    // One write; captures the RAM port in the cycle after the write edge
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; data_in = d; write_en = 1'b1;
        @(posedge clk); #1;
        cap_wren = ram_wren; cap_addr = ram_wraddress;
        cap_data = ram_data; cap_en = enable_osd;
        write_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        addr = a;
        @(posedge clk); #1;
        d = data_out;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        n_cmp++; if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL rst_ram_wren: got %b want 0", ram_wren); end
        n_cmp++; if (ram_wraddress !== 10'h000) begin n_bad++; $display("FAIL rst_ram_wraddress: got %h want 000", ram_wraddress); end
        n_cmp++; if (enable_osd !== 1'b0) begin n_bad++; $display("FAIL rst_enable_osd: got %b want 0", enable_osd); end
        @(posedge clk); #1; reset_n = 1'b1;
        do_read(8'h80, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rst_bank_rd: got %h want 00", rd); end
    endtask

    task automatic test_window;
        do_write(8'h80, 8'hFB);
        do_read(8'h80, rd);
        n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL bank_upper_ignored: got %h want 03", rd); end
        c0 = wren_cnt;
        do_write(8'h12, 8'h05);
        n_cmp++; if (cap_wren !== 1'b1) begin n_bad++; $display("FAIL win_wren: got %b want 1", cap_wren); end
        n_cmp++; if (cap_addr !== 10'h192) begin n_bad++; $display("FAIL win_addr: got %h want 192", cap_addr); end
        n_cmp++; if (cap_data !== 8'h05) begin n_bad++; $display("FAIL win_data: got %h want 05", cap_data); end
        n_cmp++; if (wren_cnt - c0 !== 1) begin n_bad++; $display("FAIL win_pulse_count: got %0d want 1", wren_cnt - c0); end
        n_cmp++; if (ram_wraddress !== 10'h192) begin n_bad++; $display("FAIL win_addr_hold: got %h want 192", ram_wraddress); end
        do_read(8'h87, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unmapped_rd: got %h want 00", rd); end
    endtask

    task automatic test_stream;
        do_write(8'h81, 8'h04);
        do_write(8'h82, 8'hFE);
        do_write(8'h83, 8'hFF);
        do_read(8'h83, rd);
        n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL ptrh_rd: got %h want 03", rd); end
        do_read(8'h82, rd);
        n_cmp++; if (rd !== 8'hFE) begin n_bad++; $display("FAIL ptrl_rd: got %h want fe", rd); end
        do_write(8'h84, 8'hA1);
        n_cmp++; if (cap_wren !== 1'b1 || cap_addr !== 10'h3FE || cap_data !== 8'hA1) begin n_bad++; $display("FAIL stream0: got %b/%h/%h want 1/3fe/a1", cap_wren, cap_addr, cap_data); end
        do_read(8'h85, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL flags_prewrap: got %h want 00", rd); end
        do_write(8'h84, 8'hA2);
        n_cmp++; if (cap_wren !== 1'b1 || cap_addr !== 10'h3FF || cap_data !== 8'hA2) begin n_bad++; $display("FAIL stream1: got %b/%h/%h want 1/3ff/a2", cap_wren, cap_addr, cap_data); end
        do_write(8'h84, 8'hA3);
        n_cmp++; if (cap_wren !== 1'b1 || cap_addr !== 10'h000 || cap_data !== 8'hA3) begin n_bad++; $display("FAIL stream2: got %b/%h/%h want 1/000/a3", cap_wren, cap_addr, cap_data); end
        do_read(8'h85, rd);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL flags_wrap: got %h want 01", rd); end
        do_read(8'h82, rd);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL ptr_after_wrap: got %h want 01", rd); end
    endtask

    task automatic test_protect;
        do_write(8'h81, 8'h04);
        do_write(8'h81, 8'h02);
        do_read(8'h81, rd);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL ctrl_rd_wp: got %h want 02", rd); end
        c0 = wren_cnt;
        do_write(8'h10, 8'h33);
        n_cmp++; if (cap_wren !== 1'b0) begin n_bad++; $display("FAIL wp_win_wren: got %b want 0", cap_wren); end
        do_write(8'h84, 8'h44);
        n_cmp++; if (cap_wren !== 1'b0) begin n_bad++; $display("FAIL wp_stream_wren: got %b want 0", cap_wren); end
        n_cmp++; if (wren_cnt - c0 !== 0) begin n_bad++; $display("FAIL wp_pulse_count: got %0d want 0", wren_cnt - c0); end
        do_read(8'h82, rd);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL wp_ptr_same: got %h want 01", rd); end
        do_read(8'h85, rd);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL flags_blocked: got %h want 02", rd); end
        do_write(8'h81, 8'h04);
        do_read(8'h85, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL flags_cleared: got %h want 00", rd); end
        do_read(8'h81, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL ctrl_selfclear: got %h want 00", rd); end
    endtask

    task automatic test_back_to_back;
        c0 = wren_cnt;
        @(posedge clk); #1;
        addr = 8'h05; data_in = 8'h5A; write_en = 1'b1;
        repeat (20) @(posedge clk);
        #1; write_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wren_cnt - c0 !== 1) begin n_bad++; $display("FAIL hold_pulse_count: got %0d want 1", wren_cnt - c0); end
        n_cmp++; if (ram_wraddress !== 10'h185 || ram_data !== 8'h5A) begin n_bad++; $display("FAIL hold_addr_data: got %h/%h want 185/5a", ram_wraddress, ram_data); end
    endtask

    task automatic test_snapshot;
        status_bus[7:0]     = 8'h11;
        status_bus[31:24]   = 8'h44;
        status_bus[255:248] = 8'h5C;
        do_write(8'h86, 8'h00);
        status_bus[7:0]     = 8'h22;
        do_read(8'h90, rd);
        n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL snap_byte0_old: got %h want 11", rd); end
        do_read(8'h93, rd);
        n_cmp++; if (rd !== 8'h44) begin n_bad++; $display("FAIL snap_byte3: got %h want 44", rd); end
        do_read(8'hAF, rd);
        n_cmp++; if (rd !== 8'h5C) begin n_bad++; $display("FAIL snap_byte31: got %h want 5c", rd); end
        do_write(8'h86, 8'h00);
        do_read(8'h90, rd);
        n_cmp++; if (rd !== 8'h22) begin n_bad++; $display("FAIL snap_byte0_new: got %h want 22", rd); end
        do_write(8'h90, 8'hFF);
        n_cmp++; if (cap_wren !== 1'b0) begin n_bad++; $display("FAIL status_wr_wren: got %b want 0", cap_wren); end
        do_read(8'h90, rd);
        n_cmp++; if (rd !== 8'h22) begin n_bad++; $display("FAIL status_wr_ignored: got %h want 22", rd); end
        do_read(8'hB0, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL past_status_rd: got %h want 00", rd); end
    endtask

    task automatic test_reset_mid_write;
        do_write(8'h81, 8'h01);
        n_cmp++; if (cap_en !== 1'b1) begin n_bad++; $display("FAIL enable_osd_set: got %b want 1", cap_en); end
        do_write(8'h80, 8'h05);
        @(posedge clk); #1;
        addr = 8'h20; data_in = 8'h77; write_en = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ram_wren !== 1'b1 || ram_wraddress !== 10'h2A0) begin n_bad++; $display("FAIL pre_reset_wr: got %b/%h want 1/2a0", ram_wren, ram_wraddress); end
        #2; reset_n = 1'b0;
        #1;
        n_cmp++; if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL mid_rst_wren: got %b want 0", ram_wren); end
        n_cmp++; if (ram_wraddress !== 10'h000 || ram_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_ram: got %h/%h want 000/00", ram_wraddress, ram_data); end
        n_cmp++; if (enable_osd !== 1'b0 || data_out !== 8'h00) begin n_bad++; $display("FAIL mid_rst_outs: got %b/%h want 0/00", enable_osd, data_out); end
        write_en = 1'b0; addr = 8'h00;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        do_read(8'h80, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL post_rst_bank: got %h want 00", rd); end
        n_cmp++; if (enable_osd !== 1'b0) begin n_bad++; $display("FAIL post_rst_enable: got %b want 0", enable_osd); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; wren_cnt = 0;
        reset_n = 1'b0; addr = 8'h00; data_in = 8'h00; write_en = 1'b0;
        status_bus = '0;
        cap_wren = 1'b0; cap_addr = '0; cap_data = '0; cap_en = 1'b0; rd = '0; c0 = 0;
        test_reset;
        test_window;
        test_stream;
        test_protect;
        test_back_to_back;
        test_snapshot;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
